// File: rtl/fp_stream_reducer.sv
`default_nettype none
// ============================================================================
// Module   : fp_stream_reducer
// Brief    : Sums a stream of IEEE-754 words through an external pipelined
//            fp_adder, pairing inputs and partial sums so an add can issue
//            every cycle. Optional checker enabled by FP_REDUCER_CHECK_EN.
// Revision : 1.0
// ============================================================================
module fp_stream_reducer #(
    parameter int  WIDTH   = 32,
    parameter int  LATENCY = 11,
    parameter int  MAX_LEN = 1024,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LW-1:0]    len,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             sum_valid,
    output logic             busy,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_ready,
    input  logic [WIDTH-1:0] add_o,
    input  logic             add_valid
`ifdef FP_REDUCER_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam int IW = $clog2(LATENCY + 2);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LW-1:0]    r_len_q;
    logic [LW-1:0]    r_recv_cnt;
    logic [IW-1:0]    r_inflight;
    logic [WIDTH-1:0] r_pending;
    logic             r_pending_v;
    logic [WIDTH-1:0] r_sum;
    logic             r_sum_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic             r_add_ready;

    logic [LW-1:0]    w_len_nxt;
    logic [LW-1:0]    w_recv_nxt;
    logic [IW-1:0]    w_inflight_nxt;
    logic [WIDTH-1:0] w_pending_nxt;
    logic             w_pending_v_nxt;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_sum_valid_nxt;
    logic [WIDTH-1:0] w_add_a_nxt;
    logic [WIDTH-1:0] w_add_b_nxt;
    logic             w_add_ready_nxt;

    logic             w_in_take;
    logic [1:0]       w_ncand;
    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_second;
    logic             w_done;
    logic             w_issue;

    assign w_in_take = in_valid && (r_recv_cnt < r_len_q);
    assign w_ncand   = {1'b0, r_pending_v} + {1'b0, add_valid} + {1'b0, w_in_take};
    assign w_issue   = (r_state == S_RUN) && !w_done && (w_ncand >= 2'd2);
    assign w_done    = (r_recv_cnt == r_len_q) && (r_inflight == '0)
                       && !add_valid && r_pending_v;

    // Priority pending > add_o > in_data; the in_data word is always the leftover.
    always_comb begin
        w_first  = in_data;
        w_second = in_data;
        if (r_pending_v) begin
            w_first  = r_pending;
            w_second = add_valid ? add_o : in_data;
        end else if (add_valid) begin
            w_first  = add_o;
            w_second = in_data;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len_q;
        w_recv_nxt      = r_recv_cnt;
        w_inflight_nxt  = r_inflight;
        w_pending_nxt   = r_pending;
        w_pending_v_nxt = r_pending_v;
        w_sum_nxt       = r_sum;
        w_sum_valid_nxt = 1'b0;
        w_add_a_nxt     = r_add_a;
        w_add_b_nxt     = r_add_b;
        w_add_ready_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_len_nxt       = len;
                    w_recv_nxt      = '0;
                    w_inflight_nxt  = '0;
                    w_pending_v_nxt = 1'b0;
                    if (len == '0) begin
                        w_sum_nxt       = '0;
                        w_sum_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_done) begin
                    w_sum_nxt       = r_pending;
                    w_sum_valid_nxt = 1'b1;
                    w_pending_v_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end else begin
                    if (w_in_take) begin
                        w_recv_nxt = r_recv_cnt + 1'b1;
                    end
                    w_inflight_nxt = r_inflight + IW'(w_issue) - IW'(add_valid);
                    case (w_ncand)
                        2'd3: begin
                            w_add_a_nxt     = w_first;
                            w_add_b_nxt     = w_second;
                            w_add_ready_nxt = 1'b1;
                            w_pending_nxt   = in_data;
                            w_pending_v_nxt = 1'b1;
                        end
                        2'd2: begin
                            w_add_a_nxt     = w_first;
                            w_add_b_nxt     = w_second;
                            w_add_ready_nxt = 1'b1;
                            w_pending_v_nxt = 1'b0;
                        end
                        2'd1: begin
                            w_pending_nxt   = w_first;
                            w_pending_v_nxt = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len_q     <= '0;
            r_recv_cnt  <= '0;
            r_inflight  <= '0;
            r_pending   <= '0;
            r_pending_v <= 1'b0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len_q     <= w_len_nxt;
            r_recv_cnt  <= w_recv_nxt;
            r_inflight  <= w_inflight_nxt;
            r_pending   <= w_pending_nxt;
            r_pending_v <= w_pending_v_nxt;
            r_sum       <= w_sum_nxt;
            r_sum_valid <= w_sum_valid_nxt;
            r_busy      <= (w_state_nxt == S_RUN);
            r_add_a     <= w_add_a_nxt;
            r_add_b     <= w_add_b_nxt;
            r_add_ready <= w_add_ready_nxt;
        end
    end

    assign sum       = r_sum;
    assign sum_valid = r_sum_valid;
    assign busy      = r_busy;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_ready = r_add_ready;

`ifdef FP_REDUCER_CHECK_EN
    logic w_err_ret_empty;
    logic w_err_ret_idle;
    logic w_err_overrun;
    logic r_err;

    assign w_err_ret_empty = add_valid && (r_inflight == '0);
    assign w_err_ret_idle  = add_valid && (r_state == S_IDLE);
    assign w_err_overrun   = in_valid && (r_state == S_RUN) && (r_recv_cnt == r_len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_ret_empty || w_err_ret_idle || w_err_overrun) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    a_ret_empty: assert property (@(posedge clk) disable iff (rst) !w_err_ret_empty);
    a_ret_idle:  assert property (@(posedge clk) disable iff (rst) !w_err_ret_idle);
    a_overrun:   assert property (@(posedge clk) disable iff (rst) !w_err_overrun);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_stream_reducer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_stream_reducer
// Brief    : Directed bench for fp_stream_reducer with a behavioural fp_adder
//            and a queue of expected sums.
// Revision : 1.0
// ============================================================================
module tb_fp_stream_reducer;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 11;
    localparam int MAX_LEN = 1024;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic             clk;
    logic             rst;
    logic             start;
    logic [LW-1:0]    len;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             sum_valid;
    logic             busy;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_ready;
    logic [WIDTH-1:0] add_o;
    logic             add_valid;
`ifdef FP_REDUCER_CHECK_EN
    logic             err;
`endif

    fp_stream_reducer #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .sum       (sum),
        .sum_valid (sum_valid),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ready (add_ready),
        .add_o     (add_o),
        .add_valid (add_valid)
`ifdef FP_REDUCER_CHECK_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-precision <-> real conversion for normal numbers and zero.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:23] == 8'd0) return 0.0;
        b = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [10:0] e;
        logic [30:0] m;
        b = $realtobits(r);
        if (b[62:52] == 11'd0) return {b[63], 31'd0};
        e = b[62:52] - 11'd896;
        m = {e[7:0], b[51:29]} + {30'd0, b[28]};
        return {b[63], m};
    endfunction

    // Behavioural pipelined fp_adder sharing rst.
    logic [WIDTH-1:0] pipe_d [LATENCY];
    logic             pipe_v [LATENCY];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe_d[k] <= '0;
                pipe_v[k] <= 1'b0;
            end
        end else begin
            pipe_v[0] <= add_ready;
            pipe_d[0] <= r2f(f2r(add_a) + f2r(add_b));
            for (int k = 1; k < LATENCY; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_d[k] <= pipe_d[k-1];
            end
        end
    end

    assign add_o     = pipe_d[LATENCY-1];
    assign add_valid = pipe_v[LATENCY-1];

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  n_rdy = 0;
    int  n_sv  = 0;
    int  sv_cyc = 0;
    int  ifl   = 0;
    int  max_ifl = 0;
    int  last_send_cyc = 0;
    int  start_cyc = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    real sb[$];
    real vals[$];
    int  gaps[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            ifl = 0;
        end else begin
            if (add_ready) begin
                n_rdy++;
                last_a = add_a;
                last_b = add_b;
                ifl++;
            end
            if (add_valid) ifl--;
            if (ifl > max_ifl) max_ifl = ifl;
            if (sum_valid) begin
                real o, e, d;
                bit  ok;
                n_sv++;
                sv_cyc = cyc;
                o = f2r(sum);
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $error("FAIL unexpected_sum observed=%h expected=none", sum);
                end else begin
                    e  = sb.pop_front();
                    d  = (o > e) ? (o - e) : (e - o);
                    ok = (d <= 1.0e-5 * ((e < 0.0) ? -e : e));
                    assert (ok === 1'b1) else begin
                        bad++;
                        $error("FAIL sum observed=%f expected=%f", o, e);
                    end
                end
            end
        end
    end

    task automatic start_run(input int n);
        @(negedge clk);
        start     = 1'b1;
        len       = LW'(n);
        start_cyc = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        @(negedge clk);
        in_valid      = 1'b1;
        in_data       = v;
        last_send_cyc = cyc + 1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_seq(input int n);
        real e;
        e = 0.0;
        foreach (vals[i]) e += f2r(r2f(vals[i]));
        sb.push_back(e);
        start_run(n);
        foreach (vals[i]) begin
            repeat (gaps[i]) idle();
            send(r2f(vals[i]));
        end
        idle();
    endtask

    task automatic wait_sum(input int base, input string tag);
        int k;
        k = 0;
        while (n_sv == base && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (n_sv == base) begin
            total++;
            bad++;
            $error("FAIL %s_timeout observed=no_sum_valid expected=sum_valid", tag);
        end
    endtask

    initial begin
        int base;
        int rbase;
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sum",       64'(sum),       64'd0);
        chk("rst_sum_valid", 64'(sum_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_add_a",     64'(add_a),     64'd0);
        chk("rst_add_b",     64'(add_b),     64'd0);
        chk("rst_add_ready", 64'(add_ready), 64'd0);
        @(negedge clk) rst = 1'b0;

        // Basic pair
        vals = '{1.0, 2.0}; gaps = '{0, 0};
        base = n_sv; rbase = n_rdy;
        run_seq(2);
        wait_sum(base, "pair");
        chk("pair_adds",    64'(n_rdy - rbase), 64'd1);
        chk("pair_a",       64'(last_a), 64'(r2f(1.0)));
        chk("pair_b",       64'(last_b), 64'(r2f(2.0)));
        chk("pair_latency", 64'(sv_cyc - last_send_cyc), 64'(LATENCY + 2));

        // Mixed signs
        vals = '{1.3, -14.8}; gaps = '{0, 0};
        base = n_sv;
        run_seq(2);
        wait_sum(base, "mixed");
        chk("mixed_busy", 64'(busy), 64'd0);

        // Streaming 1..16
        vals.delete(); gaps.delete();
        for (int i = 1; i <= 16; i++) begin
            vals.push_back(real'(i));
            gaps.push_back(0);
        end
        base = n_sv; rbase = n_rdy; max_ifl = 0;
        run_seq(16);
        wait_sum(base, "stream");
        repeat (LATENCY + 4) @(posedge clk);
        #1;
        chk("stream_adds",     64'(n_rdy - rbase), 64'd15);
        chk("stream_inflight", 64'(max_ifl <= LATENCY), 64'd1);
        chk("stream_sv_count", 64'(n_sv - base), 64'd1);

        // Gaps
        vals = '{0.5, 0.5, 0.5, 0.5, 0.5}; gaps = '{0, 0, 3, 12, 0};
        base = n_sv;
        run_seq(5);
        wait_sum(base, "gaps");

        // len = 1
        vals = '{7.25}; gaps = '{0};
        base = n_sv; rbase = n_rdy;
        run_seq(1);
        wait_sum(base, "len1");
        chk("len1_latency", 64'(sv_cyc - last_send_cyc), 64'd1);
        chk("len1_no_add",  64'(n_rdy - rbase), 64'd0);

        // Reset mid-run
        base = n_sv;
        start_run(8);
        for (int i = 1; i <= 4; i++) send(r2f(real'(i)));
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mrst_sum",       64'(sum),       64'd0);
        chk("mrst_sum_valid", 64'(sum_valid), 64'd0);
        chk("mrst_busy",      64'(busy),      64'd0);
        chk("mrst_add_a",     64'(add_a),     64'd0);
        chk("mrst_add_b",     64'(add_b),     64'd0);
        chk("mrst_add_ready", 64'(add_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (LATENCY + 4) @(posedge clk);
        #1;
        chk("mrst_no_sum", 64'(n_sv - base), 64'd0);

        vals = '{3.0, 4.0}; gaps = '{0, 0};
        base = n_sv;
        run_seq(2);
        wait_sum(base, "post_rst");

        // len = 0
        base = n_sv;
        sb.push_back(0.0);
        start_run(0);
        wait_sum(base, "len0");
        chk("len0_latency", 64'(sv_cyc - start_cyc), 64'd0);

        // Stray inputs beyond len
        base = n_sv;
        sb.push_back(3.0);
        start_run(2);
        send(r2f(1.0));
        send(r2f(2.0));
        send(r2f(100.0));
        send(r2f(100.0));
        idle();
        wait_sum(base, "stray");
`ifdef FP_REDUCER_CHECK_EN
        chk("stray_err", 64'(err), 64'd1);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_stream_reducer.md
Name: fp_stream_reducer

Overview:
- Sums a stream of `len` IEEE-754 values into one result.
- Drives an external pipelined `fp_adder` from the initiator side: raises `ready` with operands `a`/`b`, and collects `o` when `valid` comes back LATENCY cycles later.
- Pairs incoming elements, returning partial sums and one pending slot so that an add can issue every cycle.
- Used as the dot-product and row-sum reduction stage in the LCMV datapath.

Parameters:
- WIDTH, 32, float word width; must match the attached fp_adder.
- LATENCY, 11, fp_adder latency in cycles from the `ready` pulse to the `valid` pulse.
- MAX_LEN, 1024, maximum stream length; LW = $clog2(MAX_LEN+1).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a reduction; sampled only in IDLE.
- len  in  LW  element count, latched on `start`.
- in_data  in  WIDTH  stream element.
- in_valid  in  1  `in_data` is valid this cycle; always accepted in RUN, no backpressure.
- sum  out  WIDTH  reduction result; holds its value until the next result.
- sum_valid  out  1  one-cycle pulse marking `sum` valid.
- busy  out  1  high in RUN.
- add_a  out  WIDTH  operand to fp_adder `a`.
- add_b  out  WIDTH  operand to fp_adder `b`.
- add_ready  out  1  one-cycle issue pulse to fp_adder `ready`.
- add_o  in  WIDTH  fp_adder result `o`.
- add_valid  in  1  fp_adder `valid`.

Behaviour:
- Reset values: sum=0, sum_valid=0, busy=0, add_a=0, add_b=0, add_ready=0. Internal reset: state=IDLE, pending_v=0, recv_cnt=0, inflight=0.
- All outputs are registered.
- States: IDLE, RUN.
- IDLE:
  - On `start`, latch `len`, clear the counters, and go to RUN.
  - `in_valid` and `add_valid` are ignored.
  - If `start` arrives with len=0: sum=0, sum_valid pulses next cycle, and the state stays IDLE.
- RUN, each cycle, build the candidate set from three sources:
  - the pending slot, if pending_v;
  - add_o, if add_valid;
  - in_data, if in_valid and recv_cnt<len_q.
- Inputs arriving with in_valid once recv_cnt==len_q are dropped.
- Issue rule:
  - 2 or 3 candidates: issue exactly two, in priority order pending > add_o > in_data, as add_a = first and add_b = second.
  - add_ready pulses next cycle; inflight increments.
  - With 3 candidates the leftover goes into the pending slot.
  - 1 candidate: it is written to the pending slot (pending_v=1).
  - 0 candidates: nothing happens.
  - The pending slot never needs more than one entry.
- Counters:
  - recv_cnt increments on each accepted element.
  - inflight is incremented on issue and decremented on add_valid; both events in the same cycle leave it unchanged.
  - inflight never exceeds LATENCY.
- Completion: in RUN, when recv_cnt==len_q, inflight==0, add_valid==0, in_valid irrelevant, and pending_v==1:
  - sum ← pending;
  - sum_valid pulses on the next edge;
  - pending_v←0, state→IDLE, busy falls on the same edge.
- len=1: the element goes to pending and sum_valid asserts the cycle after acceptance; no add is issued.
- `start` during RUN is ignored.
- Reset mid-run aborts the reduction: no sum_valid is produced. The fp_adder shares `rst`, so no stale results return.
- Additions are non-associative, so the result order depends on arrival timing. This is accepted; the bench compares with tolerance 1e-5 relative.

Optional Feature:
- Macro: FP_REDUCER_CHECK_EN.
- When defined, adds output `err` (1 bit, reset 0, sticky until rst). It sets on any of:
  - add_valid while inflight==0;
  - add_valid in IDLE;
  - in_valid while recv_cnt==len_q in RUN.
- When defined, it also adds simulation assertions for the same three conditions.
- Without the macro there is no `err` port and no checking logic; behaviour is otherwise identical.

Test Plan:
- Basic pair: start with len=2, in_data 1.0 then 2.0 on consecutive cycles → one add_ready pulse with a=1.0, b=2.0; sum_valid LATENCY+2 cycles after the second element; sum=3.0.
- Mixed signs: len=2, values 1.3 and -14.8 → sum=-13.5 within tolerance; busy is low after sum_valid.
- Streaming: len=16, values 1.0..16.0 back-to-back → add_ready at most once per cycle; inflight ≤ LATENCY; sum=136.0; exactly one sum_valid pulse.
- Gaps and degenerate lengths:
  - len=5, values 0.5 each with in_valid idle gaps of 0, 3 and 12 cycles → sum=2.5;
  - len=1 with value 7.25 → sum=7.25 one cycle after acceptance, no add_ready;
  - len=0 → sum=0.0, sum_valid one cycle after start.
- Reset and stray inputs:
  - rst asserted mid-run of len=8 → all outputs return to reset values immediately; the following len=2 run of 3.0 and 4.0 gives 7.0;
  - extra in_valid beyond len is ignored; with FP_REDUCER_CHECK_EN defined, err=1 in that case.
